// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, constants and byte-merge helper for regfile_mp
//
// Purpose: common definitions for the multi-port register file.
//   - DEFAULT_WIDTH / DEFAULT_DEPTH : default geometry
//   - state_e                       : clear-engine FSM states
//   - byte_merge()                  : strobe-controlled byte merge of two words
// Ports: none (package).
package regfile_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 32;

  // byte_merge works on a fixed maximum word; callers zero-extend their
  // operands and truncate the result back to their own WIDTH (<= MERGE_MAX_W).
  localparam int MERGE_MAX_W  = 512;
  localparam int MERGE_MAX_NB = MERGE_MAX_W / 8;

  typedef enum logic {
    IDLE     = 1'b0,
    CLEARING = 1'b1
  } state_e;

  function automatic logic [MERGE_MAX_W-1:0] byte_merge(
    input logic [MERGE_MAX_W-1:0]  old_d,
    input logic [MERGE_MAX_W-1:0]  new_d,
    input logic [MERGE_MAX_NB-1:0] strb
  );
    logic [MERGE_MAX_W-1:0] res;
    res = old_d;
    for (int b = 0; b < MERGE_MAX_NB; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_d[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_wmerge.sv
// rtl/regfile_wmerge.sv - priority byte merge of all write ports for one address
//
// Purpose: start from i_old and overlay, byte by byte, the strobed bytes of
// every enabled write port whose address equals i_addr. Ports are applied in
// ascending order so the highest-numbered port wins a contested byte.
// Ports:
//   i_addr  [AW]          address this merge is evaluated for
//   i_old   [WIDTH]       current stored contents of that address
//   i_waddr [NWRITE*AW]   write addresses, port k at [k*AW +: AW]
//   i_wen   [NWRITE]      per-port write enables
//   i_wstrb [NWRITE*NB]   per-port byte strobes
//   i_wdata [NWRITE*WIDTH] per-port write data
//   o_data  [WIDTH]       merged word
module regfile_wmerge
  import regfile_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int AW     = 5,
  parameter int NWRITE = 2
) (
  input  logic [AW-1:0]           i_addr,
  input  logic [WIDTH-1:0]        i_old,
  input  logic [NWRITE*AW-1:0]    i_waddr,
  input  logic [NWRITE-1:0]       i_wen,
  input  logic [NWRITE*WIDTH/8-1:0] i_wstrb,
  input  logic [NWRITE*WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0]        o_data
);

  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] w_acc;

  always_comb begin
    w_acc = i_old;
    for (int k = 0; k < NWRITE; k++) begin
      if (i_wen[k] && (i_waddr[k*AW +: AW] == i_addr)) begin
        w_acc = WIDTH'(byte_merge(MERGE_MAX_W'(w_acc),
                                  MERGE_MAX_W'(i_wdata[k*WIDTH +: WIDTH]),
                                  MERGE_MAX_NB'(i_wstrb[k*NB +: NB])));
      end
    end
  end

  assign o_data = w_acc;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port register file with bypass and bulk clear
//
// Purpose: DEPTH x WIDTH register file with NWRITE strobed write ports,
// NREAD combinational read ports, optional read-during-write bypass,
// optional hardwired zero entry and a sequenced bulk-clear engine.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   i_waddr  [NWRITE*AW]    write addresses
//   i_wen    [NWRITE]       write enables
//   i_wstrb  [NWRITE*NB]    byte strobes
//   i_wdata  [NWRITE*WIDTH] write data
//   i_raddr  [NREAD*AW]     read addresses
//   o_rdata  [NREAD*WIDTH]  read data (combinational)
//   i_clr    start bulk clear
//   o_busy   clear engine running
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NWRITE*$clog2(DEPTH)-1:0] i_waddr,
  input  logic [NWRITE-1:0]              i_wen,
  input  logic [NWRITE*WIDTH/8-1:0]      i_wstrb,
  input  logic [NWRITE*WIDTH-1:0]        i_wdata,
  input  logic [NREAD*$clog2(DEPTH)-1:0] i_raddr,
  output logic [NREAD*WIDTH-1:0]         o_rdata,
  input  logic                           i_clr,
  output logic                           o_busy
);

  localparam int AW = $clog2(DEPTH);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [AW-1:0]    r_ptr;
  logic             w_busy;
  logic             w_ptr_last;
  logic             w_wr_ok;
  logic [WIDTH-1:0] w_mem [DEPTH];

  assign w_ptr_last = (r_ptr == AW'(DEPTH - 1));
  // The edge that samples clr in IDLE also drops writes.
  assign w_wr_ok    = (r_state == IDLE) && !i_clr;

  // Clear FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Clear FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (i_clr)      w_state_nxt = CLEARING;
      CLEARING: if (w_ptr_last) w_state_nxt = IDLE;
      default:                  w_state_nxt = IDLE;
    endcase
  end

  // Clear FSM: outputs
  always_comb begin
    w_busy = (r_state == CLEARING);
  end

  assign o_busy = w_busy;

  // Pointer sits at 0 in IDLE so it is 0 on entry to CLEARING.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                 r_ptr <= '0;
    else if (w_busy && !w_ptr_last) r_ptr <= r_ptr + 1'b1;
    else                          r_ptr <= '0;
  end

  // Storage: one register per entry, each fed by its own write merge.
  for (genvar d = 0; d < DEPTH; d++) begin : g_mem
    if (ZERO_REG && (d == 0)) begin : g_zero
      assign w_mem[d] = '0;
    end else begin : g_entry
      logic [WIDTH-1:0] r_q;
      logic [WIDTH-1:0] w_merged;

      regfile_wmerge #(
        .WIDTH  (WIDTH),
        .AW     (AW),
        .NWRITE (NWRITE)
      ) u_wmerge (
        .i_addr  (AW'(d)),
        .i_old   (r_q),
        .i_waddr (i_waddr),
        .i_wen   (i_wen),
        .i_wstrb (i_wstrb),
        .i_wdata (i_wdata),
        .o_data  (w_merged)
      );

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                          r_q <= '0;
        else if (w_busy && (r_ptr == AW'(d)))  r_q <= '0;
        else if (w_wr_ok)                      r_q <= w_merged;
      end

      assign w_mem[d] = r_q;
    end
  end

  // Read ports
  for (genvar r = 0; r < NREAD; r++) begin : g_rd
    logic [AW-1:0]    w_ra;
    logic [WIDTH-1:0] w_stored;
    logic [WIDTH-1:0] w_byp;
    logic             w_byp_en;

    assign w_ra     = i_raddr[r*AW +: AW];
    assign w_stored = w_mem[w_ra];
    // Bypass is held off during reset so rdata stays 0 even with live write inputs.
    assign w_byp_en = BYPASS && !w_busy && i_rst_n;

    regfile_wmerge #(
      .WIDTH  (WIDTH),
      .AW     (AW),
      .NWRITE (NWRITE)
    ) u_rmerge (
      .i_addr  (w_ra),
      .i_old   (w_stored),
      .i_waddr (i_waddr),
      .i_wen   (i_wen),
      .i_wstrb (i_wstrb),
      .i_wdata (i_wdata),
      .o_data  (w_byp)
    );

    assign o_rdata[r*WIDTH +: WIDTH] = (ZERO_REG && (w_ra == '0)) ? '0 :
                                       w_byp_en                   ? w_byp :
                                                                    w_stored;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp (bypass and non-bypass instances)
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  waddr = '0;
  logic [1:0]  wen = '0;
  logic [7:0]  wstrb = '0;
  logic [63:0] wdata = '0;
  logic [9:0]  raddr = '0;
  logic        clr = 1'b0;
  logic [63:0] rd_b, rd_n;
  logic        busy_b, busy_n;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;
  logic [31:0] m [32];

  always #5 clk = ~clk;

  regfile_mp #(.WIDTH(32), .DEPTH(32), .NREAD(2), .NWRITE(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut_byp (
    .i_clk(clk), .i_rst_n(rst_n), .i_waddr(waddr), .i_wen(wen), .i_wstrb(wstrb), .i_wdata(wdata),
    .i_raddr(raddr), .o_rdata(rd_b), .i_clr(clr), .o_busy(busy_b));

  regfile_mp #(.WIDTH(32), .DEPTH(32), .NREAD(2), .NWRITE(2), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_nob (
    .i_clk(clk), .i_rst_n(rst_n), .i_waddr(waddr), .i_wen(wen), .i_wstrb(wstrb), .i_wdata(wdata),
    .i_raddr(raddr), .o_rdata(rd_n), .i_clr(clr), .o_busy(busy_n));

  // Reference view of an address this cycle: per byte, the highest enabled
  // strobed port hitting the address wins; otherwise the stored byte.
  function automatic logic [31:0] view(input logic [4:0] a);
    logic [31:0] r;
    if (a == 5'd0) return 32'h0;
    r = m[a];
    for (int b = 0; b < 4; b++) begin
      for (int k = 1; k >= 0; k--) begin
        if (wen[k] && waddr[k*5 +: 5] == a && wstrb[k*4 + b]) begin
          r[b*8 +: 8] = wdata[k*32 + b*8 +: 8];
          break;
        end
      end
    end
    return r;
  endfunction

  task automatic idle_in();
    wen = '0; wstrb = '0; waddr = '0; wdata = '0; clr = 1'b0;
  endtask

  task automatic set_w(input int k, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    wen[k] = 1'b1; waddr[k*5 +: 5] = a; wdata[k*32 +: 32] = d; wstrb[k*4 +: 4] = s;
  endtask

  task automatic commit();
    if (!clr) for (int a = 1; a < 32; a++) m[a] = view(5'(a));
  endtask

  task automatic model_zero();
    for (int a = 0; a < 32; a++) m[a] = 32'h0;
  endtask

  task automatic test_reset();
    idle_in();
    @(negedge clk);
    raddr = {5'd9, 5'd5};
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy_b !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy_b); else n_pass++;
    n_checks++; if (rd_b !== 64'h0) $display("FAIL reset_rdata got %h exp 0", rd_b); else n_pass++;
    model_zero();
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      raddr = {5'(31 - a), 5'(a)};
      #1;
      exp_q.push_back(m[a]); exp_q.push_back(m[31 - a]);
      e = exp_q.pop_front(); n_checks++;
      if (rd_b[31:0] !== e) $display("FAIL reset_scan_p0 a=%0d got %h exp %h", a, rd_b[31:0], e); else n_pass++;
      e = exp_q.pop_front(); n_checks++;
      if (rd_b[63:32] !== e) $display("FAIL reset_scan_p1 a=%0d got %h exp %h", 31 - a, rd_b[63:32], e); else n_pass++;
    end
  endtask

  task automatic test_write_strobe();
    @(negedge clk);
    idle_in(); set_w(0, 5'd5, 32'hDEADBEEF, 4'hF); raddr = {5'd0, 5'd5};
    exp_q.push_back(32'hDEADBEEF);
    #1; commit();
    @(negedge clk);
    idle_in(); set_w(0, 5'd5, 32'h11223344, 4'h3); raddr = {5'd0, 5'd5};
    exp_q.push_back(32'hDEAD3344);
    #1;
    e = exp_q.pop_front(); n_checks++;
    if (rd_n[31:0] !== e) $display("FAIL write_full got %h exp %h", rd_n[31:0], e); else n_pass++;
    e = exp_q.pop_front(); n_checks++;
    if (rd_b[31:0] !== e) $display("FAIL write_strobe_bypass got %h exp %h", rd_b[31:0], e); else n_pass++;
    commit();
    @(negedge clk);
    idle_in();
    exp_q.push_back(32'hDEAD3344);
    #1;
    e = exp_q.pop_front(); n_checks++;
    if (rd_n[31:0] !== e) $display("FAIL write_strobe got %h exp %h", rd_n[31:0], e); else n_pass++;
  endtask

  task automatic test_collision();
    @(negedge clk);
    idle_in();
    set_w(0, 5'd7, 32'hAAAAAAAA, 4'hF); set_w(1, 5'd7, 32'h55555555, 4'hC);
    raddr = {5'd8, 5'd7};
    exp_q.push_back(32'h5555AAAA);
    #1;
    e = exp_q.pop_front(); n_checks++;
    if (rd_b[31:0] !== e) $display("FAIL collide_bypass got %h exp %h", rd_b[31:0], e); else n_pass++;
    commit();
    @(negedge clk);
    idle_in();
    set_w(0, 5'd8, 32'h01020304, 4'h5); set_w(1, 5'd8, 32'hA0B0C0D0, 4'h6);
    exp_q.push_back(32'h5555AAAA);
    #1;
    e = exp_q.pop_front(); n_checks++;
    if (rd_n[31:0] !== e) $display("FAIL collide_full got %h exp %h", rd_n[31:0], e); else n_pass++;
    commit();
    @(negedge clk);
    idle_in();
    exp_q.push_back(32'h00B0C004);
    #1;
    e = exp_q.pop_front(); n_checks++;
    if (rd_n[63:32] !== e) $display("FAIL collide_partial got %h exp %h", rd_n[63:32], e); else n_pass++;
  endtask

  task automatic test_bypass();
    @(negedge clk);
    idle_in(); set_w(0, 5'd9, 32'hCAFEF00D, 4'hF);
    #1; commit();
    @(negedge clk);
    idle_in(); set_w(1, 5'd9, 32'h12345678, 4'hF); raddr = {5'd9, 5'd9};
    exp_q.push_back(32'h12345678); exp_q.push_back(32'hCAFEF00D);
    #1;
    e = exp_q.pop_front(); n_checks++;
    if (rd_b[31:0] !== e) $display("FAIL bypass_on got %h exp %h", rd_b[31:0], e); else n_pass++;
    e = exp_q.pop_front(); n_checks++;
    if (rd_n[31:0] !== e) $display("FAIL bypass_off_before got %h exp %h", rd_n[31:0], e); else n_pass++;
    commit();
    @(negedge clk);
    idle_in();
    exp_q.push_back(32'h12345678); exp_q.push_back(32'h12345678);
    #1;
    e = exp_q.pop_front(); n_checks++;
    if (rd_b[63:32] !== e) $display("FAIL bypass_on_after got %h exp %h", rd_b[63:32], e); else n_pass++;
    e = exp_q.pop_front(); n_checks++;
    if (rd_n[63:32] !== e) $display("FAIL bypass_off_after got %h exp %h", rd_n[63:32], e); else n_pass++;
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    idle_in(); set_w(0, 5'd0, 32'hFFFFFFFF, 4'hF); raddr = {5'd0, 5'd0};
    #1;
    n_checks++; if (rd_b !== 64'h0) $display("FAIL zero_same_cycle got %h exp 0", rd_b); else n_pass++;
    n_checks++; if (rd_n !== 64'h0) $display("FAIL zero_same_cycle_nob got %h exp 0", rd_n); else n_pass++;
    commit();
    @(negedge clk);
    idle_in();
    #1;
    n_checks++; if (rd_n[31:0] !== 32'h0) $display("FAIL zero_after got %h exp 0", rd_n[31:0]); else n_pass++;
  endtask

  task automatic test_clear();
    int  cnt;
    bit  done;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      idle_in();
      set_w(0, 5'(i), {8'hA5, 8'(i), 16'h5A5A}, 4'hF);
      set_w(1, 5'(i + 16), {8'h3C, 8'(i), 16'hC3C3}, 4'hF);
      #1; commit();
    end
    @(negedge clk);
    idle_in(); clr = 1'b1; set_w(0, 5'd10, 32'h0BADF00D, 4'hF);
    #1;
    n_checks++; if (busy_b !== 1'b0) $display("FAIL clear_busy_early got %b exp 0", busy_b); else n_pass++;
    cnt = 0; done = 1'b0;
    for (int c = 1; c <= 100 && !done; c++) begin
      @(negedge clk);
      idle_in();
      if (c == 15) clr = 1'b1;
      if (c == 21) begin set_w(0, 5'd3, 32'hFFFFFFFF, 4'hF); raddr = {5'd25, 5'd3}; end
      else raddr = {5'd1, 5'd11};
      #1;
      if (busy_b) begin
        cnt++;
        if (c == 21) begin
          exp_q.push_back(32'h0); exp_q.push_back(m[25]);
          e = exp_q.pop_front(); n_checks++;
          if (rd_b[31:0] !== e) $display("FAIL clear_mid_cleared got %h exp %h", rd_b[31:0], e); else n_pass++;
          e = exp_q.pop_front(); n_checks++;
          if (rd_b[63:32] !== e) $display("FAIL clear_mid_pending got %h exp %h", rd_b[63:32], e); else n_pass++;
        end
      end else done = 1'b1;
    end
    if (!done) begin n_checks++; $display("FAIL clear_timeout busy still %b", busy_b); end
    n_checks++; if (cnt !== 32) $display("FAIL clear_busy_cycles got %0d exp 32", cnt); else n_pass++;
    model_zero();
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      idle_in(); raddr = {5'(31 - a), 5'(a)};
      #1;
      exp_q.push_back(m[a]);
      e = exp_q.pop_front(); n_checks++;
      if (rd_n[31:0] !== e) $display("FAIL clear_scan a=%0d got %h exp %h", a, rd_n[31:0], e); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_clear();
    for (int i = 4; i < 8; i++) begin
      @(negedge clk);
      idle_in(); set_w(1, 5'(i), 32'h7700_0000 | 32'(i), 4'hF);
      #1; commit();
    end
    @(negedge clk);
    idle_in(); clr = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      idle_in(); raddr = {5'd30, 5'd6};
    end
    #1;
    n_checks++; if (busy_b !== 1'b1) $display("FAIL rmc_busy_before got %b exp 1", busy_b); else n_pass++;
    #1; rst_n = 1'b0; #1;
    n_checks++; if (busy_b !== 1'b0) $display("FAIL rmc_busy got %b exp 0", busy_b); else n_pass++;
    n_checks++; if (rd_n !== 64'h0) $display("FAIL rmc_rdata got %h exp 0", rd_n); else n_pass++;
    model_zero();
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      idle_in(); raddr = {5'(a), 5'(31 - a)};
      #1;
      exp_q.push_back(m[a]);
      e = exp_q.pop_front(); n_checks++;
      if (rd_b[63:32] !== e) $display("FAIL rmc_scan a=%0d got %h exp %h", a, rd_b[63:32], e); else n_pass++;
    end
    @(negedge clk);
    idle_in(); set_w(0, 5'd6, 32'h600D600D, 4'hF);
    #1; commit();
    @(negedge clk);
    idle_in(); raddr = {5'd0, 5'd6};
    exp_q.push_back(m[6]);
    #1;
    e = exp_q.pop_front(); n_checks++;
    if (rd_n[31:0] !== e) $display("FAIL rmc_write_after got %h exp %h", rd_n[31:0], e); else n_pass++;
  endtask

  task automatic test_random();
    logic [4:0] a;
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        idle_in();
        for (int k = 0; k < 2; k++) begin
          wen[k] = 1'($urandom_range(0, 1));
          waddr[k*5 +: 5] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
          wstrb[k*4 +: 4] = 4'($urandom_range(0, 15));
          wdata[k*32 +: 32] = $urandom;
        end
        raddr = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 3))};
        #1;
        for (int r = 0; r < 2; r++) begin
          a = raddr[r*5 +: 5];
          exp_q.push_back(view(a));
          exp_q.push_back((a == 5'd0) ? 32'h0 : m[a]);
          e = exp_q.pop_front(); n_checks++;
          if (rd_b[r*32 +: 32] !== e) $display("FAIL rand_byp ph=%0d i=%0d p=%0d got %h exp %h", ph, i, r, rd_b[r*32 +: 32], e); else n_pass++;
          e = exp_q.pop_front(); n_checks++;
          if (rd_n[r*32 +: 32] !== e) $display("FAIL rand_nob ph=%0d i=%0d p=%0d got %h exp %h", ph, i, r, rd_n[r*32 +: 32], e); else n_pass++;
        end
        commit();
      end
      if (ph == 0) begin
        @(negedge clk);
        idle_in(); rst_n = 1'b0;
        model_zero();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_strobe();
    test_collision();
    test_bypass();
    test_zero_reg();
    test_clear();
    test_reset_mid_clear();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
